// File: rtl/ps2_scan_ctrl_if.sv
// Scan-code byte input and decoded-event output handshake of ps2_scan_ctrl.
// The master side is the receiver/consumer pair; the slave side is the sequencer.
`timescale 1ns/1ps
interface ps2_scan_ctrl_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_repeat;

  modport master (
    output byte_valid, byte_data, ev_ready,
    input  ev_valid, ev_code, ev_ext, ev_break, ev_repeat
  );

  modport slave (
    input  byte_valid, byte_data, ev_ready,
    output ev_valid, ev_code, ev_ext, ev_break, ev_repeat
  );
endinterface

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: E0/F0 prefix parsing, typematic repeat filtering,
// show-ahead event FIFO, key-held flag and two-digit BCD press counter.
`timescale 1ns/1ps
module ps2_scan_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  ps2_scan_ctrl_if.slave bus,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  output logic          key_down,
  output logic [7:0]    press_bcd
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] code;
  } entry_t;

  state_t        state_q, state_d;
  logic          emit, emit_ext, emit_brk, is_ctrl, is_e0, is_f0;
  logic          held_q, hext_q;
  logic [7:0]    hcode_q;
  logic          is_rep, new_press, rel_match;
  logic [7:0]    bcd_next;
  entry_t        entry_d, head;
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, push, pop;

  assign is_e0 = (bus.byte_data == 8'hE0);
  assign is_f0 = (bus.byte_data == 8'hF0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_ctrl = 1'b0;
    case (bus.byte_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default:                                  is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (bus.byte_valid) begin
      if (is_ctrl) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (is_e0)      state_d = EXT;
            else if (is_f0) state_d = BRK;
            else            emit    = 1'b1;
          end
          EXT: begin
            if (is_f0)       state_d = EXT_BRK;
            else if (!is_e0) begin
              emit = 1'b1; emit_ext = 1'b1; state_d = IDLE;
            end
          end
          BRK: begin
            if (is_e0)       state_d = EXT_BRK;
            else if (!is_f0) begin
              emit = 1'b1; emit_brk = 1'b1; state_d = IDLE;
            end
          end
          EXT_BRK: begin
            if (!is_e0 && !is_f0) begin
              emit = 1'b1; emit_ext = 1'b1; emit_brk = 1'b1; state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // A make of the key already held is a typematic repeat, not a new press.
  assign is_rep    = emit && !emit_brk && held_q &&
                     ({emit_ext, bus.byte_data} == {hext_q, hcode_q});
  assign new_press = emit && !emit_brk && !is_rep;
  assign rel_match = emit && emit_brk && ({emit_ext, bus.byte_data} == {hext_q, hcode_q});
  assign entry_d   = '{ext: emit_ext, brk: emit_brk, rep: is_rep, code: bus.byte_data};

  always_comb begin
    bcd_next = press_bcd;
    if (press_bcd[3:0] == 4'd9) begin
      bcd_next[3:0] = 4'd0;
      bcd_next[7:4] = (press_bcd[7:4] == 4'd9) ? 4'd0 : press_bcd[7:4] + 4'd1;
    end else begin
      bcd_next[3:0] = press_bcd[3:0] + 4'd1;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full = (fifo_count == CW'(FIFO_DEPTH));
  assign pop  = bus.ev_valid && bus.ev_ready;
  assign push = emit && (!full || pop);

  // NOTE: the storage array is deliberately not reset; the occupancy count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      held_q     <= 1'b0;
      hext_q     <= 1'b0;
      hcode_q    <= '0;
      press_bcd  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (emit && full && !pop) overflow <= 1'b1;
      if (new_press) begin
        held_q    <= 1'b1;
        hext_q    <= emit_ext;
        hcode_q   <= bus.byte_data;
        press_bcd <= bcd_next;
      end else if (rel_match) begin
        held_q <= 1'b0;
      end
    end
  end

  // Head fields are forced to zero while empty so reset and idle outputs are clean.
  assign head          = mem[rd_ptr];
  assign bus.ev_valid  = (fifo_count != '0);
  assign bus.ev_code   = bus.ev_valid ? head.code : 8'h00;
  assign bus.ev_ext    = bus.ev_valid && head.ext;
  assign bus.ev_break  = bus.ev_valid && head.brk;
  assign bus.ev_repeat = bus.ev_valid && head.rep;
  assign key_down      = held_q;
endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Self-checking bench for ps2_scan_ctrl: a prefix-flag/queue model checked every cycle,
// plus directed scenarios with hand-computed event logs and counter values.
`timescale 1ns/1ps
module tb_ps2_scan_ctrl;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] code;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] fifo_count;
  logic          overflow, key_down;
  logic [7:0]    press_bcd;

  ps2_scan_ctrl_if bus();

  ps2_scan_ctrl #(.FIFO_DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .key_down   (key_down),
    .press_bcd  (press_bcd)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: pending prefixes as flags, event queue, held key and a plain press count.
  ev_t        mq[$];
  ev_t        lg[$];
  bit         m_ext, m_brk, m_held, m_hext, m_ovf;
  logic [7:0] m_hcode;
  int         m_presses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input bit ext, input bit brk, input bit rep, input logic [7:0] code);
    ev_t e;
    e.ext = ext; e.brk = brk; e.rep = rep; e.code = code;
    return e;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    int v;
    v = n % 100;
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  always @(posedge clk) begin : model_and_compare
    bit  pop, em;
    ev_t e, hd;
    if (rst) begin
      mq.delete();
      m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_hcode = 8'h00;
      m_ovf = 0; m_presses = 0;
    end else begin
      if (bus.ev_valid === 1'b1 && bus.ev_ready)
        lg.push_back(mk(bus.ev_ext, bus.ev_break, bus.ev_repeat, bus.ev_code));
      pop = (mq.size() > 0) && bus.ev_ready;
      em  = 0;
      e   = '0;
      if (bus.byte_valid) begin
        if (bus.byte_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
          m_ext = 0; m_brk = 0;
        end else if (bus.byte_data == 8'hE0) begin
          m_ext = 1;
        end else if (bus.byte_data == 8'hF0) begin
          m_brk = 1;
        end else begin
          em = 1;
          e  = mk(m_ext, m_brk, 0, bus.byte_data);
          m_ext = 0; m_brk = 0;
        end
      end
      if (em) begin
        if (!e.brk) begin
          if (m_held && m_hext == e.ext && m_hcode == e.code) begin
            e.rep = 1;
          end else begin
            m_held = 1; m_hext = e.ext; m_hcode = e.code; m_presses++;
          end
        end else if (m_hext == e.ext && m_hcode == e.code) begin
          m_held = 0;
        end
      end
      if (pop) void'(mq.pop_front());
      if (em) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else                   m_ovf = 1;
      end
    end
    #2;
    hd = (mq.size() > 0) ? mq[0] : '0;
    check("ev_valid",   bus.ev_valid,  mq.size() > 0);
    check("ev_code",    bus.ev_code,   hd.code);
    check("ev_ext",     bus.ev_ext,    hd.ext);
    check("ev_break",   bus.ev_break,  hd.brk);
    check("ev_repeat",  bus.ev_repeat, hd.rep);
    check("fifo_count", fifo_count,    mq.size());
    check("overflow",   overflow,      m_ovf);
    check("key_down",   key_down,      m_held);
    check("press_bcd",  press_bcd,     to_bcd(m_presses));
  end

  task automatic tick(input logic bv, input logic [7:0] bd);
    bus.byte_valid = bv;
    bus.byte_data  = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] bd);
    tick(1'b1, bd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    lg.delete();
  endtask

  logic [7:0] codes [9];

  initial begin
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.ev_ready   = 1'b1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    lg.delete();
    check("reset_press_bcd", press_bcd, 8'h00);
    check("reset_key_down",  key_down,  1'b0);

    // Plain make/break
    send(8'h1C);
    check("plain_key_down_make", key_down, 1'b1);
    send(8'hF0);
    send(8'h1C);
    check("plain_key_down_break", key_down, 1'b0);
    idle(2);
    check("plain_events", lg.size(), 2);
    if (lg.size() == 2) begin
      check("plain_ev0", lg[0], mk(0, 0, 0, 8'h1C));
      check("plain_ev1", lg[1], mk(0, 1, 0, 8'h1C));
    end
    check("plain_press_bcd", press_bcd, 8'h01);

    // Extended key
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    idle(2);
    check("ext_events", lg.size(), 2);
    if (lg.size() == 2) begin
      check("ext_ev0", lg[0], mk(1, 0, 0, 8'h75));
      check("ext_ev1", lg[1], mk(1, 1, 0, 8'h75));
    end

    // Typematic repeats
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    idle(2);
    check("typ_events", lg.size(), 5);
    if (lg.size() == 5) begin
      check("typ_ev0", lg[0], mk(0, 0, 0, 8'h1C));
      check("typ_ev1", lg[1], mk(0, 0, 1, 8'h1C));
      check("typ_ev2", lg[2], mk(0, 0, 1, 8'h1C));
      check("typ_ev3", lg[3], mk(0, 1, 0, 8'h1C));
      check("typ_ev4", lg[4], mk(0, 0, 0, 8'h1C));
    end
    check("typ_press_bcd", press_bcd, 8'h02);

    // Overflow, then push-while-full with a simultaneous pop
    do_reset();
    bus.ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(codes[i]);
    idle(1);
    check("ovf_count",    fifo_count, 8);
    check("ovf_flag",     overflow,   1'b1);
    check("ovf_head",     bus.ev_code, 8'h15);
    check("ovf_press",    press_bcd,  8'h09);
    bus.ev_ready = 1'b1;
    send(8'h4B);
    check("full_pushpop_count", fifo_count, 8);
    idle(10);
    check("drain_events", lg.size(), 9);
    for (int i = 0; i < lg.size() && i < 8; i++) check("drain_code", lg[i].code, codes[i]);
    if (lg.size() == 9) check("drain_last", lg[8].code, 8'h4B);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_press_10", press_bcd, 8'h10);

    // BCD wrap over 100 presses
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      send(8'h1C);
      if (i == 9)   check("bcd_09", press_bcd, 8'h09);
      if (i == 10)  check("bcd_10", press_bcd, 8'h10);
      if (i == 99)  check("bcd_99", press_bcd, 8'h99);
      if (i == 100) check("bcd_00", press_bcd, 8'h00);
      send(8'hF0);
      send(8'h1C);
    end
    idle(2);

    // Reset mid-sequence; a byte offered during reset is ignored
    do_reset();
    bus.ev_ready = 1'b0;
    send(8'h1C);
    send(8'hE0);
    check("pre_rst_count", fifo_count, 1);
    rst = 1'b1;
    tick(1'b1, 8'hF0);
    check("rst_ev_valid", bus.ev_valid, 1'b0);
    check("rst_count",    fifo_count,   0);
    check("rst_key_down", key_down,     1'b0);
    check("rst_press",    press_bcd,    8'h00);
    rst = 1'b0;
    bus.ev_ready = 1'b1;
    send(8'h75);
    idle(2);
    check("rst_events", lg.size(), 1);
    if (lg.size() == 1) check("rst_ev0", lg[0], mk(0, 0, 0, 8'h75));

    // Control bytes cancel pending prefixes
    do_reset();
    send(8'hF0); send(8'hFA); send(8'h1C);
    send(8'hE0); send(8'hAA); send(8'h75);
    idle(2);
    check("ctrl_events", lg.size(), 2);
    if (lg.size() == 2) begin
      check("ctrl_ev0", lg[0], mk(0, 0, 0, 8'h1C));
      check("ctrl_ev1", lg[1], mk(0, 0, 0, 8'h75));
    end
    check("ctrl_press", press_bcd, 8'h02);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
